recur_engine: RTL

Parametrised second-order linear recurrence engine, the successor to the fixed inc/add/×14 recursive datapath. It computes x_k = P·x_{k-1} + Q·x_{k-2} + R (mod 2^WIDTH) from seeds x_0 and x_1 up to a programmable index n. Each iteration takes one clock cycle. Compared with the previous block, it adds:
- run-time coefficients;
- a start/busy/ready handshake;
- abort;
- a sticky overflow flag.

It sits between the host-side operand registers and the result consumer.

---
 rtl/recur_engine.sv | 139 +++++++++++++
 1 files changed

// File: rtl/recur_engine.sv
// recur_engine: second-order linear recurrence x_k = P*x_{k-1} + Q*x_{k-2} + R
// (mod 2^WIDTH), one step per clock, with start/abort handshake and sticky
// overflow flag.
module recur_engine #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din_x0,
    input  logic [WIDTH-1:0] din_x1,
    input  logic [WIDTH-1:0] coef_p,
    input  logic [WIDTH-1:0] coef_q,
    input  logic [WIDTH-1:0] coef_r,
    input  logic [CNT_W-1:0] n,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] idx,
    output logic             busy,
    output logic             ready,
    output logic             ovf
);

    localparam int unsigned TW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] idx_reg;
    logic             ovf_reg;

    logic [TW-1:0]    term;
    logic [CNT_W-1:0] idx_inc;
    logic             last_step;
    logic             accept;
    logic             n_small;

    // Full-precision recurrence term, step bookkeeping and start acceptance
    always_comb begin
        term = {{(WIDTH + 1){1'b0}}, p_reg} * {{(WIDTH + 1){1'b0}}, a_reg}
             + {{(WIDTH + 1){1'b0}}, q_reg} * {{(WIDTH + 1){1'b0}}, b_reg}
             + {{(WIDTH + 1){1'b0}}, r_reg};
        idx_inc   = idx_reg + CNT_W'(1);
        last_step = (idx_inc == n_reg);
        // abort beats start in every state; start is ignored while running
        accept    = start && !abort && (state != RUN);
        n_small   = (n == '0) || (n == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept) begin
                    state_next = n_small ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latches, recurrence registers, index and sticky overflow
    always_ff @(posedge clk) begin
        if (res) begin
            a_reg   <= '0;
            b_reg   <= '0;
            p_reg   <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            n_reg   <= '0;
            idx_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            p_reg   <= coef_p;
            q_reg   <= coef_q;
            r_reg   <= coef_r;
            n_reg   <= n;
            ovf_reg <= 1'b0;
            if (n == '0) begin
                a_reg   <= din_x0;
                b_reg   <= '0;
                idx_reg <= '0;
            end else begin
                a_reg   <= din_x1;
                b_reg   <= din_x0;
                idx_reg <= CNT_W'(1);
            end
        end else if (state == RUN && !abort) begin
            a_reg   <= term[WIDTH-1:0];
            b_reg   <= a_reg;
            idx_reg <= idx_inc;
            if (term[TW-1:WIDTH] != '0) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Output decodes of registered state
    always_comb begin
        out   = a_reg;
        idx   = idx_reg;
        busy  = (state == RUN);
        ready = (state == DONE);
        ovf   = ovf_reg;
    end

endmodule
